// File: rtl/i2s_pkg.sv
// Purpose : shared constants, sample-pair type and slot-to-bit helper for the I2S transmitter.
// Latency : n/a (package).
// Backpressure: n/a (package).
package i2s_pkg;

  localparam int DATA_W     = 16;    // sample width per channel
  localparam int FRAME_CLKS = 1024;  // clk cycles per LRCLK period (power of 2)
  localparam int SCLK_DIV   = 16;    // clk cycles per SCLK period

  localparam int CNT_W  = $clog2(FRAME_CLKS);     // frame counter width (10)
  localparam int SDIV_W = $clog2(SCLK_DIV);       // clk-in-slot field width (4)
  localparam int SLOT_W = CNT_W - 1 - SDIV_W;     // slot index width (5 -> 32 slots/channel)
  localparam int IDX_W  = $clog2(DATA_W);         // bit index within a sample

  // I2S places the MSB one SCLK after the LRCLK edge.
  localparam int SLOT_MSB = 1;
  localparam int SLOT_LSB = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] lft;
    logic signed [DATA_W-1:0] rht;
  } smpl_pair_t;

  // Bit driven on SDin during slot k of one channel half; zero outside the data window.
  function automatic logic slot_bit(input logic [DATA_W-1:0] word,
                                    input logic [SLOT_W-1:0] k);
    if ((int'(k) >= SLOT_MSB) && (int'(k) <= SLOT_LSB)) begin
      return word[IDX_W'(SLOT_LSB - int'(k))];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_clk_gen.sv
// Purpose : free-running frame counter producing MCLK/SCLK/LRCLK plus slot strobes for the serializer.
// Latency : clocks are counter flop bits directly (0 logic levels); strobes are combinational from the count.
// Backpressure: none, free-running.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   mclk_o         cnt[1]   (clk/4)
//   sclk_o         cnt[3]   (clk/16)
//   lrclk_o        cnt[9]   (clk/1024, 0 = left half)
//   slot_edge_o    high in the cycle whose clk edge starts a new SCLK slot (cnt[3:0] == 15)
//   slot_nxt_o     slot index k of the slot that starts on that edge
//   lr_nxt_o       channel half of the slot that starts on that edge
//   frm_bnd_o      high in the last cycle of a frame (cnt == 1023)
module i2s_clk_gen
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              mclk_o,
  output logic              sclk_o,
  output logic              lrclk_o,
  output logic              slot_edge_o,
  output logic [SLOT_W-1:0] slot_nxt_o,
  output logic              lr_nxt_o,
  output logic              frm_bnd_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wraps naturally at FRAME_CLKS since the frame length is a power of 2.
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Codec clocks come straight off counter flops so they are glitch-free.
  assign mclk_o  = cnt_q[1];
  assign sclk_o  = cnt_q[SDIV_W-1];
  assign lrclk_o = cnt_q[CNT_W-1];

  // SCLK falls on the edge where the low field wraps; SDin changes there and
  // is stable for the codec at the following SCLK rise.
  assign slot_edge_o = &cnt_q[SDIV_W-1:0];
  assign slot_nxt_o  = cnt_d[CNT_W-2:SDIV_W];
  assign lr_nxt_o    = cnt_d[CNT_W-1];

  assign frm_bnd_o = &cnt_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Purpose : buffers one left/right pair and serializes it MSB-first onto SDin in I2S format, mastering MCLK/SCLK/LRCLK.
// Latency : pair accepted in frame N is sent in frame N+1; left MSB reaches SDin at cnt=16 of that frame.
// Backpressure: smpl_rdy (registered) low while the single-entry buffer is full; it frees at each frame boundary.
//
// Ports:
//   clk, rst           system clock (50 MHz), synchronous active-high reset
//   lft_in, rht_in     signed 16-bit sample pair
//   smpl_vld/smpl_rdy  valid/ready handshake, transfer on smpl_vld & smpl_rdy
//   frm_strt           one-clk pulse when a buffered pair enters the shift stage
//   underrun           one-clk pulse when a frame boundary finds the buffer empty
//   MCLK, SCLK, LRCLK  codec clocks (clk/4, clk/16, clk/1024)
//   SDin               serial data to the codec, sampled by it on SCLK rise
module i2s_tx_serializer
  import i2s_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] lft_in,
  input  logic signed [DATA_W-1:0] rht_in,
  input  logic                     smpl_vld,
  output logic                     smpl_rdy,
  output logic                     frm_strt,
  output logic                     underrun,
  output logic                     MCLK,
  output logic                     SCLK,
  output logic                     LRCLK,
  output logic                     SDin
);

  logic              slot_edge;
  logic [SLOT_W-1:0] slot_nxt;
  logic              lr_nxt;
  logic              frm_bnd;

  i2s_clk_gen u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .mclk_o      (MCLK),
    .sclk_o      (SCLK),
    .lrclk_o     (LRCLK),
    .slot_edge_o (slot_edge),
    .slot_nxt_o  (slot_nxt),
    .lr_nxt_o    (lr_nxt),
    .frm_bnd_o   (frm_bnd)
  );

  smpl_pair_t buf_q,      buf_d;
  logic       buf_full_q, buf_full_d;
  smpl_pair_t act_q,      act_d;
  logic       rdy_q,      rdy_d;
  logic       frm_strt_q, frm_strt_d;
  logic       underrun_q, underrun_d;
  logic       sdin_q,     sdin_d;
  logic       accept;

  assign accept = smpl_vld & rdy_q;

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    act_d      = act_q;
    frm_strt_d = 1'b0;
    underrun_d = 1'b0;
    sdin_d     = sdin_q;

    // Frame boundary: promote the buffered pair, or send silence.
    if (frm_bnd) begin
      if (buf_full_q) begin
        act_d      = buf_q;
        buf_full_d = 1'b0;
        frm_strt_d = 1'b1;
      end else begin
        act_d      = '0;
        underrun_d = 1'b1;
      end
    end

    // rdy_q is low whenever the buffer is full, so an accept never collides
    // with the promotion above; an accept on an empty boundary feeds the next frame.
    if (accept) begin
      buf_d.lft  = lft_in;
      buf_d.rht  = rht_in;
      buf_full_d = 1'b1;
    end

    // act_q is used even on the boundary edge: the slot starting there is
    // slot 0, which drives 0 regardless of the active pair.
    if (slot_edge) begin
      sdin_d = slot_bit(lr_nxt ? act_q.rht : act_q.lft, slot_nxt);
    end

    rdy_d = ~buf_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      act_q      <= '0;
      rdy_q      <= 1'b0;
      frm_strt_q <= 1'b0;
      underrun_q <= 1'b0;
      sdin_q     <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      act_q      <= act_d;
      rdy_q      <= rdy_d;
      frm_strt_q <= frm_strt_d;
      underrun_q <= underrun_d;
      sdin_q     <= sdin_d;
    end
  end

  assign smpl_rdy = rdy_q;
  assign frm_strt = frm_strt_q;
  assign underrun = underrun_q;
  assign SDin     = sdin_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lft_in = '0;
  logic [15:0] rht_in = '0;
  logic        smpl_vld = 1'b0;
  logic        smpl_rdy, frm_strt, underrun, MCLK, SCLK, LRCLK, SDin;

  always #5 clk = ~clk;

  i2s_tx_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .lft_in   (lft_in),
    .rht_in   (rht_in),
    .smpl_vld (smpl_vld),
    .smpl_rdy (smpl_rdy),
    .frm_strt (frm_strt),
    .underrun (underrun),
    .MCLK     (MCLK),
    .SCLK     (SCLK),
    .LRCLK    (LRCLK),
    .SDin     (SDin)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state expected to be visible after the most recent clk edge.
  bit          m_known = 1'b0;
  logic [9:0]  m_cnt = '0;
  bit          m_full = 1'b0;
  logic [15:0] m_bl = '0, m_br = '0;
  bit          m_rdy = 1'b0, m_frm = 1'b0, m_und = 1'b0;
  logic [31:0] exp_q[$];        // scoreboard: {lft,rht} expected per transmitted frame
  int          n_acc = 0, n_und = 0, n_frm = 0, n_dec = 0;

  // Codec receiver model state.
  bit          d_sclk = 1'b0, d_lr = 1'b0;
  int          d_slot = -1;
  logic [15:0] d_l = '0, d_r = '0;
  logic [31:0] last_dec = '0;
  logic [31:0] e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      chk("clocks", {29'd0, MCLK, SCLK, LRCLK}, {29'd0, m_cnt[1], m_cnt[3], m_cnt[9]});
      chk("smpl_rdy", {31'd0, smpl_rdy}, {31'd0, m_rdy});
      chk("frm_strt", {31'd0, frm_strt}, {31'd0, m_frm});
      chk("underrun", {31'd0, underrun}, {31'd0, m_und});
      if (m_cnt == 10'd0) chk("sdin_slot0", {31'd0, SDin}, 32'd0);
      if (underrun === 1'b1) n_und++;
      if (frm_strt === 1'b1) n_frm++;

      // Codec: sample SDin on SCLK rise, slot counted from the last LRCLK change.
      if (SCLK === 1'b1 && d_sclk == 1'b0) begin
        if (LRCLK !== d_lr) d_slot = 0; else d_slot++;
        d_lr = LRCLK;
        if (d_slot >= 1 && d_slot <= 16) begin
          if (LRCLK) d_r = {d_r[14:0], SDin};
          else       d_l = {d_l[14:0], SDin};
        end else begin
          chk("sdin_idle_slot", {31'd0, SDin}, 32'd0);
        end
        if (LRCLK === 1'b1 && d_slot == 31) begin
          last_dec = {d_l, d_r};
          n_dec++;
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL frame_unexpected observed=%h expected=none", last_dec);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_lft", {16'd0, d_l}, {16'd0, e[31:16]});
            chk("frame_rht", {16'd0, d_r}, {16'd0, e[15:0]});
          end
        end
      end
      d_sclk = SCLK;
    end

    // Advance the model across the coming posedge.
    if (rst) begin
      m_cnt = '0; m_full = 0; m_rdy = 0; m_frm = 0; m_und = 0;
      exp_q.delete();
      exp_q.push_back(32'd0);   // active pair is cleared, first frame is silent
      d_slot = -1; d_lr = 0; d_sclk = 0;
      m_known = 1;
    end else if (m_known) begin
      m_frm = 0; m_und = 0;
      if (m_cnt == 10'd1023) begin
        if (m_full) begin
          exp_q.push_back({m_bl, m_br});
          m_full = 0; m_frm = 1;
        end else begin
          exp_q.push_back(32'd0);
          m_und = 1;
        end
      end
      if (smpl_vld && m_rdy) begin
        m_bl = lft_in; m_br = rht_in; m_full = 1;
        n_acc++;
      end
      m_rdy = !m_full;
      m_cnt = m_cnt + 10'd1;
    end
  end

  task automatic wait_cnt(input int v);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (int'(m_cnt) != v && n < 3000);
    checks++;
    assert (int'(m_cnt) == v) else begin
      errors++;
      $error("FAIL wait_cnt observed=%0d expected=%0d", m_cnt, v);
    end
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int start = n_acc;
    int n = 0;
    lft_in = l; rht_in = r; smpl_vld = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (n_acc == start && n < 3000);
    checks++;
    assert (n_acc != start) else begin
      errors++;
      $error("FAIL send_timeout observed=%0d expected=%0d", n_acc, start + 1);
    end
    smpl_vld = 1'b0;
  endtask

  int u0, a0, f0;
  int s;

  initial begin
    // Reset, then idle: one underrun per frame, silent frames.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    u0 = n_und;
    repeat (4) wait_cnt(512);
    chk("idle_underruns", 32'(n_und - u0), 32'd3);

    // Single pair accepted mid-frame, sent in the next frame.
    f0 = n_frm;
    send_pair(16'h8001, 16'h7FFE);
    repeat (2) wait_cnt(1020);
    chk("single_pair_decode", last_dec, 32'h8001_7FFE);
    chk("single_frm_strt", 32'(n_frm - f0), 32'd1);

    // Back-to-back ramp: one acceptance per frame, right after each boundary.
    u0 = n_und;
    for (int i = 0; i < 6; i++) begin
      send_pair(16'(i), 16'(i + 100));
      if (i > 0) chk("stream_accept_phase", {22'd0, m_cnt}, 32'd1);
    end
    chk("stream_no_underrun", 32'(n_und - u0), 32'd0);
    repeat (2) wait_cnt(1020);
    chk("stream_last", last_dec, {16'd5, 16'd105});

    // Late arrival exactly at the boundary with the buffer empty.
    wait_cnt(1023);
    u0 = n_und; a0 = n_acc;
    lft_in = 16'hA5A5; rht_in = 16'h5A5A; smpl_vld = 1'b1;
    @(posedge clk); #1;
    smpl_vld = 1'b0;
    chk("late_accepted", 32'(n_acc - a0), 32'd1);
    wait_cnt(1020);
    chk("late_underrun", 32'(n_und - u0), 32'd1);
    chk("late_not_current", last_dec, 32'd0);
    wait_cnt(1020);
    chk("late_next_frame", last_dec, 32'hA5A5_5A5A);
    chk("late_single_underrun", 32'(n_und - u0), 32'd1);

    // Reset mid-frame with the buffer full: pair dropped, first frame underruns.
    wait_cnt(100);
    send_pair(16'h1234, 16'h4321);
    wait_cnt(500);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_outputs", {25'd0, MCLK, SCLK, LRCLK, SDin, frm_strt, underrun, smpl_rdy}, 32'd0);
    rst = 1'b0;
    u0 = n_und;
    wait_cnt(1020);
    chk("rst_frame0", last_dec, 32'd0);
    chk("rst_no_early_underrun", 32'(n_und - u0), 32'd0);
    wait_cnt(1020);
    chk("rst_dropped_pair", last_dec, 32'd0);
    chk("rst_first_underrun", 32'(n_und - u0), 32'd1);

    // 1 kHz full-scale sine at fs through the codec model.
    for (int n = 0; n < 24; n++) begin
      s = $rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * 1000.0 * n / 48828.125) + 0.5));
      send_pair(16'(s), 16'(-s));
    end
    repeat (2) wait_cnt(1020);
    s = $rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * 1000.0 * 23 / 48828.125) + 0.5));
    chk("sine_last", last_dec, {16'(s), 16'(-s)});
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Codec-side transmitter: takes parallel 16-bit left/right sample pairs from the equalizer datapath and serializes them onto SDin toward the CS4272 in I2S format.
- Master for the codec serial port: generates MCLK, SCLK and LRCLK from clk (50 MHz), giving fs = 50 MHz/1024 = 48828 Hz.
- Counterpart of the codec-to-equalizer receive path; sits between the filter/volume output stage and the codec pins.

Parameters:
- DATA_W, 16, sample width per channel.
- FRAME_CLKS, 1024, clk cycles per LRCLK period (power of 2).
- SCLK_DIV, 16, clk cycles per SCLK period (32 SCLK slots per channel).

Ports:
- clk  in  1  system clock, 50 MHz; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- lft_in  in  16  signed left sample.
- rht_in  in  16  signed right sample.
- smpl_vld  in  1  lft_in/rht_in valid.
- smpl_rdy  out  1  holding buffer empty; transfer occurs when smpl_vld & smpl_rdy.
- frm_strt  out  1  one-clk pulse when a pair moves into the shift stage.
- underrun  out  1  one-clk pulse at a frame boundary with no pair buffered.
- MCLK  out  1  clk/4 (12.5 MHz).
- SCLK  out  1  clk/16.
- LRCLK  out  1  clk/1024; 0 = left slot, 1 = right slot.
- SDin  out  1  serial data to codec.

Behaviour:
- Free-running 10-bit counter cnt; reset to 0, +1 every clk, wraps 1023->0.
- MCLK = cnt[1], SCLK = cnt[3], LRCLK = cnt[9], all taken directly from counter flops with no extra logic. SCLK falls when cnt[3:0] goes 15->0. The codec samples SDin on SCLK rise.
- Slot index k = cnt[8:4] (0..31) within each channel half.
- I2S framing: MSB is in slot k=1, LSB in slot k=16. Slots 0 and 17..31 drive 0.
- SDin is registered and updates only on the clk edge where cnt[3:0] 15->0. On that edge it takes the bit for the new slot: act_lft[16-k] when LRCLK=0, act_rht[16-k] when LRCLK=1.
- Holding buffer: one entry {buf_lft, buf_rht, buf_full}.
  - smpl_rdy = ~buf_full, registered.
  - On vld & rdy: capture both inputs and set buf_full. smpl_rdy drops the next cycle.
- Frame boundary is the cycle with cnt==1023.
  - If buf_full: act_lft/act_rht <= buffer, buf_full <= 0, frm_strt = 1 next cycle.
  - Else: act_lft/act_rht <= 0, underrun = 1 next cycle.
- Accept and boundary in the same cycle cannot happen, because rdy=0 whenever the buffer is full. If the buffer is empty at the boundary, an acceptance in that same cycle fills the buffer for the NEXT frame; that boundary still underruns.
- Latency: a pair accepted in frame N is transmitted in frame N+1. Left MSB first appears on SDin at cnt=16 of that frame.
- Sustained throughput: one pair per 1024 clk.
- Reset (including mid-frame), effective the cycle after rst sampled high:
  - cnt = 0, act/buffer cleared, buf_full = 0.
  - MCLK = SCLK = LRCLK = SDin = 0, frm_strt = underrun = 0.
  - smpl_rdy = 0 while rst is high, 1 the first cycle after rst deasserts.
- Sample data is two's complement and passed bit-exact; no rounding or saturation.

Decomposition:
- Package i2s_pkg holds: DATA_W, FRAME_CLKS, SCLK_DIV; SLOT_MSB = 1, SLOT_LSB = 16; typedef smpl_pair_t (struct of signed [15:0] lft, rht).
- One sub-module, i2s_clk_gen: counter plus MCLK/SCLK/LRCLK/slot index/boundary strobe.
- The buffer and serializer stay in the top module.

Test Plan:
- Reset then idle: after rst deasserts, LRCLK period = 1024 clk, SCLK = 16 clk, MCLK = 4 clk. underrun pulses every 1024 clk. SDin stays 0.
- Single pair lft=16'h8001, rht=16'h7FFE, accepted during frame 0: frm_strt at cnt=0 of frame 1.
  - Left slots 1..16 sampled on SCLK rise read 1000_0000_0000_0001.
  - Right slots read 0111_1111_1111_1110.
  - All other slots read 0.
- Back-to-back stream: smpl_vld held high with a ramp 0,1,2,...
  - Exactly one acceptance per frame; smpl_rdy low from acceptance to the next boundary.
  - Decoded codec samples equal the ramp delayed one frame; no underrun.
- Late arrival: smpl_vld asserted exactly at cnt=1023 with the buffer empty.
  - underrun pulses at that boundary.
  - The pair is transmitted in the frame after, not the current one.
- Reset mid-frame at cnt=500 with the buffer full: the cycle after rst, all outputs = 0 and cnt = 0. The buffered pair is discarded, so the first frame after reset underruns.
- Codec loopback: drive a 1 kHz full-scale sine at fs through the CS4272 model. The model's aout_lft/aout_rht match the input samples exactly, one frame late.
